cacc_dlv_addr_gen: RTL and testbench

CACC_DLV_ADDR_GEN -- requirements
Module: cacc_dlv_addr_gen

---
 rtl/cacc_dlv_addr_gen_pkg.sv | 29 ++
 rtl/cacc_dlv_cnt.sv | 37 +++
 rtl/cacc_dlv_addr_gen.sv | 186 ++++++++++++++++++
 tb/tb_cacc_dlv_addr_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacc_dlv_addr_gen_pkg.sv
// Shared definitions for the CACC delivery address generator: FSM states,
// atom size, channels-per-surface by precision and the surface-count helper.
package cacc_dlv_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ATOM_BYTES  = 32;
    localparam int K_PREC_INT8 = 32;
    localparam int K_PREC_WIDE = 16;

    // Total surfaces for the layer: ceil(C/K) per batch times B (all fields minus-one encoded).
    function automatic logic [17:0] surf_count(input logic [12:0] channel,
                                               input logic [4:0]  batches,
                                               input logic [1:0]  precision);
        logic [13:0] chans;
        logic [13:0] surfs;
        chans = {1'b0, channel} + 14'd1;
        if (precision == 2'd0)
            surfs = (chans + 14'(K_PREC_INT8 - 1)) >> $clog2(K_PREC_INT8);
        else
            surfs = (chans + 14'(K_PREC_WIDE - 1)) >> $clog2(K_PREC_WIDE);
        return 18'(surfs) * (18'(batches) + 18'd1);
    endfunction

endpackage

// File: rtl/cacc_dlv_cnt.sv
// Wrap counter: counts up on inc_i, returns to zero after reaching max_i,
// flagging wrap_o in the incrementing cycle that performs the wrap.
module cacc_dlv_cnt #(
    parameter int WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] value_o,
    output logic             wrap_o
);
    import cacc_dlv_addr_gen_pkg::*;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign wrap_o  = inc_i && (cnt_q == max_i);
    assign value_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = (cnt_q == max_i) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cacc_dlv_addr_gen.sv
// Walks the output cube (w, then h, then surface over all batches) issuing one
// 32-byte DMA write request per atom; started and aborted via OP_ENABLE writes.
module cacc_dlv_addr_gen
    import cacc_dlv_addr_gen_pkg::*;
(
    input  logic        autosa_core_clk,
    input  logic        autosa_core_rstn,
    input  logic        op_en_trigger,
    input  logic [31:0] reg_wr_data,
    input  logic [4:0]  batches,
    input  logic [31:0] dataout_addr,
    input  logic [23:0] line_stride,
    input  logic [23:0] surf_stride,
    input  logic        line_packed,
    input  logic        surf_packed,
    input  logic [12:0] dataout_width,
    input  logic [12:0] dataout_height,
    input  logic [12:0] dataout_channel,
    input  logic [1:0]  proc_precision,
    output logic        op_en,
    output logic        dma_req_valid,
    input  logic        dma_req_ready,
    output logic [31:0] dma_req_addr,
    output logic        dma_req_last,
    output logic        layer_done
);

    localparam logic [31:0] ATOM_INC = 32'(ATOM_BYTES);

    state_e      state_q;
    logic        op_en_q;
    logic        valid_q;
    logic        done_q;
    logic [31:0] addr_q;
    logic [31:0] line_base_q;
    logic [31:0] surf_base_q;

    logic [12:0] width_q;
    logic [12:0] height_q;
    logic [12:0] channel_q;
    logic [4:0]  batches_q;
    logic [1:0]  prec_q;
    logic [23:0] line_stride_q;
    logic [23:0] surf_stride_q;
    logic        line_packed_q;
    logic        surf_packed_q;

    logic        start;
    logic        abort;
    logic        hs;
    logic        at_end;
    logic [12:0] w_cnt;
    logic [12:0] h_cnt;
    logic [17:0] s_cnt;
    logic [17:0] s_max;
    logic        w_wrap;
    logic        h_wrap;
    logic        s_wrap_unused;
    logic        wr_data_unused;
    logic [31:0] line_next;
    logic [31:0] surf_next;

    assign wr_data_unused = ^reg_wr_data[31:1];

    assign start  = (state_q == ST_IDLE) && op_en_trigger && reg_wr_data[0];
    assign abort  = (state_q == ST_RUN) && op_en_trigger && !reg_wr_data[0];
    // An abort in the same cycle as ready wins: that request is not consumed.
    assign hs     = valid_q && dma_req_ready && !abort;
    assign s_max  = surf_count(channel_q, batches_q, prec_q) - 18'd1;
    assign at_end = (w_cnt == width_q) && (h_cnt == height_q) && (s_cnt == s_max);

    assign line_next = line_packed_q ? addr_q + ATOM_INC : line_base_q + {8'd0, line_stride_q};
    assign surf_next = surf_packed_q ? addr_q + ATOM_INC : surf_base_q + {8'd0, surf_stride_q};

    cacc_dlv_cnt #(.WIDTH(13)) u_w_cnt (
        .clk_i   (autosa_core_clk),
        .rstn_i  (autosa_core_rstn),
        .clr_i   (start),
        .inc_i   (hs),
        .max_i   (width_q),
        .value_o (w_cnt),
        .wrap_o  (w_wrap)
    );

    cacc_dlv_cnt #(.WIDTH(13)) u_h_cnt (
        .clk_i   (autosa_core_clk),
        .rstn_i  (autosa_core_rstn),
        .clr_i   (start),
        .inc_i   (w_wrap),
        .max_i   (height_q),
        .value_o (h_cnt),
        .wrap_o  (h_wrap)
    );

    cacc_dlv_cnt #(.WIDTH(18)) u_s_cnt (
        .clk_i   (autosa_core_clk),
        .rstn_i  (autosa_core_rstn),
        .clr_i   (start),
        .inc_i   (h_wrap),
        .max_i   (s_max),
        .value_o (s_cnt),
        .wrap_o  (s_wrap_unused)
    );

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state_q       <= ST_IDLE;
            op_en_q       <= 1'b0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            addr_q        <= '0;
            line_base_q   <= '0;
            surf_base_q   <= '0;
            width_q       <= '0;
            height_q      <= '0;
            channel_q     <= '0;
            batches_q     <= '0;
            prec_q        <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
            line_packed_q <= 1'b0;
            surf_packed_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        width_q       <= dataout_width;
                        height_q      <= dataout_height;
                        channel_q     <= dataout_channel;
                        batches_q     <= batches;
                        prec_q        <= proc_precision;
                        line_stride_q <= line_stride;
                        surf_stride_q <= surf_stride;
                        line_packed_q <= line_packed;
                        surf_packed_q <= surf_packed;
                        addr_q        <= dataout_addr;
                        line_base_q   <= dataout_addr;
                        surf_base_q   <= dataout_addr;
                        op_en_q       <= 1'b1;
                        valid_q       <= 1'b1;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        op_en_q <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (hs) begin
                        if (at_end) begin
                            op_en_q <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (!w_wrap) begin
                            addr_q <= addr_q + ATOM_INC;
                        end else if (!h_wrap) begin
                            addr_q      <= line_next;
                            line_base_q <= line_next;
                        end else begin
                            addr_q      <= surf_next;
                            line_base_q <= surf_next;
                            surf_base_q <= surf_next;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    op_en_q <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_en         = op_en_q;
    assign dma_req_valid = valid_q;
    assign dma_req_addr  = addr_q;
    assign dma_req_last  = valid_q && at_end;
    assign layer_done    = done_q;

endmodule

// File: tb/tb_cacc_dlv_addr_gen.sv
// Directed bench for cacc_dlv_addr_gen: a nested-loop address model checked
// every cycle, plus literal address lists for the key scenarios.
module tb_cacc_dlv_addr_gen;

    typedef struct {
        logic [31:0] a;
        logic        l;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        op_en_trigger = 1'b0;
    logic [31:0] reg_wr_data = '0;
    logic [4:0]  batches = '0;
    logic [31:0] dataout_addr = '0;
    logic [23:0] line_stride = '0;
    logic [23:0] surf_stride = '0;
    logic        line_packed = 1'b0;
    logic        surf_packed = 1'b0;
    logic [12:0] dw = '0;
    logic [12:0] dh = '0;
    logic [12:0] dc = '0;
    logic [1:0]  prec = '0;
    logic        rdy = 1'b1;
    logic        op_en;
    logic        vld;
    logic [31:0] addr;
    logic        last;
    logic        layer_done;

    int          checks = 0;
    int          errors = 0;
    req_t        exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] ev[$];
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    int          done_cnt = 0;
    int          rdy_mode = 0;
    int          rdy_idx = 0;
    logic        rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    cacc_dlv_addr_gen dut (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .op_en_trigger    (op_en_trigger),
        .reg_wr_data      (reg_wr_data),
        .batches          (batches),
        .dataout_addr     (dataout_addr),
        .line_stride      (line_stride),
        .surf_stride      (surf_stride),
        .line_packed      (line_packed),
        .surf_packed      (surf_packed),
        .dataout_width    (dw),
        .dataout_height   (dh),
        .dataout_channel  (dc),
        .proc_precision   (prec),
        .op_en            (op_en),
        .dma_req_valid    (vld),
        .dma_req_ready    (rdy),
        .dma_req_addr     (addr),
        .dma_req_last     (last),
        .layer_done       (layer_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected request list from the current config, as plain nested loops.
    function automatic void build_q();
        int W, H, C, B, K, S, N;
        logic [31:0] sstart, lstart, a, last_a;
        W = int'(dw) + 1;
        H = int'(dh) + 1;
        C = int'(dc) + 1;
        B = int'(batches) + 1;
        K = (prec == 2'd0) ? 32 : 16;
        S = (C + K - 1) / K;
        N = S * B;
        exp_q.delete();
        sstart = dataout_addr;
        last_a = dataout_addr;
        for (int s = 0; s < N; s++) begin
            lstart = sstart;
            for (int h = 0; h < H; h++) begin
                a = lstart;
                for (int w = 0; w < W; w++) begin
                    exp_q.push_back('{a: a, l: (s == N-1) && (h == H-1) && (w == W-1)});
                    last_a = a;
                    a = a + 32'd32;
                end
                lstart = line_packed ? last_a + 32'd32 : lstart + {8'd0, line_stride};
            end
            sstart = surf_packed ? last_a + 32'd32 : sstart + {8'd0, surf_stride};
        end
    endfunction

    // Per-cycle compare against the model, then advance the model on the inputs
    // the DUT will sample at the coming rising edge.
    task automatic compare();
        bit nd;
        bit hl;
        if (!rstn) begin
            check("rst_valid", vld, 0);
            check("rst_op_en", op_en, 0);
            check("rst_addr", addr, 0);
            check("rst_last", last, 0);
            check("rst_done", layer_done, 0);
            m_run = 1'b0;
            m_done = 1'b0;
            exp_q.delete();
            return;
        end
        check("op_en", op_en, m_run);
        check("valid", vld, m_run);
        check("layer_done", layer_done, m_done);
        if (layer_done) done_cnt++;
        if (m_run && exp_q.size() > 0) begin
            check("addr", addr, exp_q[0].a);
            check("last", last, exp_q[0].l);
        end else if (!m_run) begin
            check("last_idle", last, 0);
        end
        nd = 1'b0;
        if (!m_run && !m_done) begin
            if (op_en_trigger && reg_wr_data[0]) begin
                build_q();
                m_run = 1'b1;
            end
        end else if (m_run) begin
            if (op_en_trigger && !reg_wr_data[0]) begin
                m_run = 1'b0;
                exp_q.delete();
            end else if (rdy && exp_q.size() > 0) begin
                got_q.push_back(addr);
                hl = exp_q[0].l;
                void'(exp_q.pop_front());
                if (hl) begin
                    m_run = 1'b0;
                    nd = 1'b1;
                end
            end
        end
        m_done = nd;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       begin rdy = rdy_pat[rdy_idx % 4]; rdy_idx++; end
            default: rdy = 1'b0;
        endcase
    endtask

    task automatic pulse(input bit d);
        logic [31:0] r;
        r = $urandom;
        r[0] = d;
        op_en_trigger = 1'b1;
        reg_wr_data = r;
        step();
        op_en_trigger = 1'b0;
        reg_wr_data = $urandom;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((m_run || m_done) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (m_run || m_done) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles, %0d requests outstanding", name, n, exp_q.size());
        end
    endtask

    task automatic chk_log(input string name);
        check({name, "_count"}, got_q.size(), ev.size());
        for (int i = 0; i < ev.size(); i++)
            if (i < got_q.size()) check(name, got_q[i], ev[i]);
    endtask

    task automatic cfg(input logic [31:0] a, input logic [12:0] w, input logic [12:0] h,
                       input logic [12:0] c, input logic [1:0] p, input logic [4:0] b,
                       input logic [23:0] ls, input logic [23:0] ss,
                       input logic lp, input logic sp);
        dataout_addr = a; dw = w; dh = h; dc = c; prec = p; batches = b;
        line_stride = ls; surf_stride = ss; line_packed = lp; surf_packed = sp;
        got_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int n;
        reg_wr_data = $urandom & 32'hFFFF_FFFE;
        repeat (3) step();
        check("lit_rst_op_en", op_en, 0);
        check("lit_rst_valid", vld, 0);
        check("lit_rst_addr", addr, 0);
        rstn = 1'b1;
        step();

        // Minimal layer
        cfg(32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse(1'b1);
        wait_idle("minimal", 20);
        ev = '{32'h1000};
        chk_log("minimal_addr");
        check("minimal_done_cnt", done_cnt, 1);

        // Strided lines
        cfg(32'h0, 1, 1, 15, 0, 0, 24'h100, 0, 0, 0);
        pulse(1'b1);
        wait_idle("lines", 40);
        ev = '{32'h0, 32'h20, 32'h100, 32'h120};
        chk_log("lines_addr");

        // Surfaces with batches; config changes mid-run must be ignored
        cfg(32'h0, 0, 0, 31, 1, 1, 0, 24'h400, 0, 0);
        pulse(1'b1);
        dataout_addr = 32'hDEAD_0000; surf_stride = 24'h10; dc = 13'd0;
        wait_idle("surf", 40);
        ev = '{32'h0, 32'h400, 32'h800, 32'hC00};
        chk_log("surf_addr");

        // Backpressure 1,0,0,1 with a redundant start write mid-run
        cfg(32'h0, 1, 1, 15, 0, 0, 24'h100, 0, 0, 0);
        rdy_mode = 1; rdy_idx = 0;
        pulse(1'b1);
        step(); step();
        pulse(1'b1);
        wait_idle("bp", 60);
        rdy_mode = 0;
        ev = '{32'h0, 32'h20, 32'h100, 32'h120};
        chk_log("bp_addr");

        // Fully packed lines and surfaces
        cfg(32'h2000, 1, 1, 63, 0, 0, 24'h800, 24'h8000, 1, 1);
        pulse(1'b1);
        wait_idle("packed", 40);
        ev.delete();
        for (int i = 0; i < 8; i++) ev.push_back(32'h2000 + 32'(i * 32));
        chk_log("packed_addr");

        // Mixed strides over several batches, model only
        cfg(32'h300, 2, 1, 40, 0, 2, 24'h80, 24'h1000, 0, 0);
        pulse(1'b1);
        wait_idle("mixed", 100);
        check("mixed_count", got_q.size(), 36);

        // Abort after the second request, then a full rerun
        cfg(32'h0, 1, 1, 15, 0, 0, 24'h100, 0, 0, 0);
        pulse(1'b1);
        n = 0;
        while (got_q.size() < 2 && n < 20) begin step(); n++; end
        check("abort_reached_two", got_q.size(), 2);
        pulse(1'b0);
        check("lit_abort_valid", vld, 0);
        check("lit_abort_op_en", op_en, 0);
        repeat (4) step();
        check("abort_no_done", done_cnt, 0);
        ev = '{32'h0, 32'h20};
        chk_log("abort_addr");
        got_q.delete();
        pulse(1'b1);
        wait_idle("rerun", 40);
        ev = '{32'h0, 32'h20, 32'h100, 32'h120};
        chk_log("rerun_addr");
        check("rerun_done_cnt", done_cnt, 1);

        // Address wrap past 2^32
        cfg(32'hFFFF_FFE0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse(1'b1);
        wait_idle("wrap", 20);
        ev = '{32'hFFFF_FFE0, 32'h0000_0000};
        chk_log("wrap_addr");

        // Asynchronous reset in the middle of a layer
        cfg(32'h0, 1, 1, 15, 0, 0, 24'h100, 0, 0, 0);
        pulse(1'b1);
        step();
        rstn = 1'b0;
        #1;
        check("lit_async_valid", vld, 0);
        check("lit_async_op_en", op_en, 0);
        step(); step();
        rstn = 1'b1;
        repeat (3) step();
        check("async_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
